// File: rtl/dp_lt_pkg.sv
// Shared DisplayPort link-training definitions.
// Holds the sequencer state encoding, AUX operation codes, link-rate and lane-count codes.
package dp_lt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_CFG,
        ST_WR_DRV,
        ST_WAIT_INT,
        ST_RD_STS,
        ST_EVAL,
        ST_ERR_CHK,
        ST_DONE,
        ST_FAIL
    } cr_state_e;

    localparam logic [1:0] AUX_OP_CFG = 2'b00;
    localparam logic [1:0] AUX_OP_DRV = 2'b01;
    localparam logic [1:0] AUX_OP_STS = 2'b10;

    localparam logic [7:0] RATE_RBR  = 8'h06;
    localparam logic [7:0] RATE_HBR  = 8'h0A;
    localparam logic [7:0] RATE_HBR2 = 8'h14;
    localparam logic [7:0] RATE_HBR3 = 8'h1E;

    localparam logic [1:0] LC_1 = 2'b00;
    localparam logic [1:0] LC_2 = 2'b01;
    localparam logic [1:0] LC_4 = 2'b11;

    // The reserved code 2'b10 is treated as a single lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] lc);
        logic [3:0] mask;
        case (lc)
            LC_2:    mask = 4'b0011;
            LC_4:    mask = 4'b1111;
            default: mask = 4'b0001;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lt_wait_timer.sv
// Loadable down-counter with a done strobe.
// Done is high in the cycle the count sits at zero after a load.
module lt_wait_timer #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load) begin
            cnt_q <= load_val;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/cr_train_ctrl.sv
// Clock-recovery link-training sequencer: config/drive/status over AUX, then pass, retry or give up.
// All outputs are registered; register values are computed from the next state.
module cr_train_ctrl
    import dp_lt_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES  = 400,
    parameter int unsigned ERR_WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cr_start,
    input  logic [7:0] link_bw_cr,
    input  logic [1:0] link_lc_cr,
    output logic       aux_req_vld,
    output logic [1:0] aux_op,
    input  logic       aux_ack,
    input  logic       aux_rsp_vld,
    input  logic       aux_rsp_err,
    input  logic [3:0] lane_cr_done,
    input  logic [7:0] adj_req_vtg,
    input  logic [7:0] adj_req_pre,
    output logic       cr_chk_start,
    output logic [7:0] adj_vtg,
    output logic [7:0] adj_pre,
    output logic       cr_completed,
    output logic       fsm_cr_failed,
    input  logic [7:0] new_bw_cr,
    input  logic [1:0] new_lc_cr,
    input  logic       drive_setting_flag,
    input  logic       bw_flag,
    input  logic       lc_flag,
    input  logic       err_cr_failed,
    output logic [7:0] cur_bw,
    output logic [1:0] cur_lc,
    output logic [7:0] vtg_set,
    output logic [7:0] pre_set,
    output logic       busy,
    output logic       cr_done,
    output logic       cr_fail
);

    localparam int unsigned MAX_CNT = (WAIT_CYCLES > ERR_WAIT_MAX) ? WAIT_CYCLES : ERR_WAIT_MAX;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_LD  = CNT_W'(ERR_WAIT_MAX - 1);

    cr_state_e  state_q, state_d;
    logic       req_q, req_d;
    logic [1:0] op_q, op_d;
    logic       acked_q, acked_d;
    logic       pass_q, pass_d;
    logic [7:0] adj_vtg_q, adj_vtg_d, adj_pre_q, adj_pre_d;
    logic [7:0] vtg_q, vtg_d, pre_q, pre_d;
    logic [7:0] bw_q, bw_d;
    logic [1:0] lc_q, lc_d;
    logic       chk_q, chk_d, compl_q, compl_d, failp_q, failp_d;
    logic       busy_q, busy_d, done_q, done_d, fail_q, fail_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             ack_now;
    logic [3:0]       mask;

    lt_wait_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign ack_now = req_q && aux_ack;
    assign mask    = lane_mask(lc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            op_q      <= 2'b00;
            acked_q   <= 1'b0;
            pass_q    <= 1'b0;
            adj_vtg_q <= '0;
            adj_pre_q <= '0;
            vtg_q     <= '0;
            pre_q     <= '0;
            bw_q      <= '0;
            lc_q      <= '0;
            chk_q     <= 1'b0;
            compl_q   <= 1'b0;
            failp_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            op_q      <= op_d;
            acked_q   <= acked_d;
            pass_q    <= pass_d;
            adj_vtg_q <= adj_vtg_d;
            adj_pre_q <= adj_pre_d;
            vtg_q     <= vtg_d;
            pre_q     <= pre_d;
            bw_q      <= bw_d;
            lc_q      <= lc_d;
            chk_q     <= chk_d;
            compl_q   <= compl_d;
            failp_q   <= failp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    // A request leaving on ack is never re-raised on the same edge; WR_DRV after WR_CFG idles one cycle.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        op_d      = op_q;
        acked_d   = acked_q;
        pass_d    = pass_q;
        adj_vtg_d = adj_vtg_q;
        adj_pre_d = adj_pre_q;
        vtg_d     = vtg_q;
        pre_d     = pre_q;
        bw_d      = bw_q;
        lc_d      = lc_q;
        chk_d     = 1'b0;
        compl_d   = 1'b0;
        failp_d   = 1'b0;
        done_d    = done_q;
        fail_d    = fail_q;
        tmr_load  = 1'b0;
        tmr_val   = WAIT_LD;

        case (state_q)
            ST_IDLE: begin
                if (cr_start) begin
                    state_d   = ST_WR_CFG;
                    bw_d      = link_bw_cr;
                    lc_d      = link_lc_cr;
                    vtg_d     = '0;
                    pre_d     = '0;
                    adj_vtg_d = '0;
                    adj_pre_d = '0;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    req_d     = 1'b1;
                    op_d      = AUX_OP_CFG;
                end
            end
            ST_WR_CFG: begin
                if (ack_now) begin
                    req_d   = 1'b0;
                    op_d    = AUX_OP_DRV;
                    state_d = ST_WR_DRV;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_WR_DRV: begin
                if (ack_now) begin
                    req_d    = 1'b0;
                    state_d  = ST_WAIT_INT;
                    tmr_load = 1'b1;
                    tmr_val  = WAIT_LD;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_WAIT_INT: begin
                if (tmr_done) begin
                    state_d = ST_RD_STS;
                    req_d   = 1'b1;
                    op_d    = AUX_OP_STS;
                    acked_d = 1'b0;
                end
            end
            ST_RD_STS: begin
                if (ack_now) begin
                    req_d   = 1'b0;
                    acked_d = 1'b1;
                end
                if (aux_rsp_vld && (acked_q || ack_now)) begin
                    state_d = ST_EVAL;
                    req_d   = 1'b0;
                    acked_d = 1'b0;
                    pass_d  = !aux_rsp_err && ((lane_cr_done & mask) == mask);
                    if (!aux_rsp_err) begin
                        adj_vtg_d = adj_req_vtg;
                        adj_pre_d = adj_req_pre;
                    end
                end
            end
            ST_EVAL: begin
                if (pass_q) begin
                    state_d = ST_DONE;
                    compl_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d  = ST_ERR_CHK;
                    chk_d    = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = ERR_LD;
                end
            end
            ST_ERR_CHK: begin
                if (err_cr_failed) begin
                    state_d = ST_FAIL;
                    failp_d = 1'b1;
                    fail_d  = 1'b1;
                end else if (lc_flag || bw_flag) begin
                    if (lc_flag) begin
                        lc_d = new_lc_cr;
                    end
                    bw_d    = new_bw_cr;
                    vtg_d   = '0;
                    pre_d   = '0;
                    state_d = ST_WR_CFG;
                    req_d   = 1'b1;
                    op_d    = AUX_OP_CFG;
                end else if (drive_setting_flag) begin
                    vtg_d   = adj_vtg_q;
                    pre_d   = adj_pre_q;
                    state_d = ST_WR_DRV;
                    req_d   = 1'b1;
                    op_d    = AUX_OP_DRV;
                end else if (tmr_done) begin
                    state_d = ST_FAIL;
                    failp_d = 1'b1;
                    fail_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign aux_req_vld   = req_q;
    assign aux_op        = op_q;
    assign cr_chk_start  = chk_q;
    assign adj_vtg       = adj_vtg_q;
    assign adj_pre       = adj_pre_q;
    assign cr_completed  = compl_q;
    assign fsm_cr_failed = failp_q;
    assign cur_bw        = bw_q;
    assign cur_lc        = lc_q;
    assign vtg_set       = vtg_q;
    assign pre_set       = pre_q;
    assign busy          = busy_q;
    assign cr_done       = done_q;
    assign cr_fail       = fail_q;

endmodule

// File: tb/tb_cr_train_ctrl.sv
// Bench for cr_train_ctrl: expected AUX ops and outcomes are queued per scenario
// and popped as the sequencer issues requests and reaches a verdict.
module tb_cr_train_ctrl;

    localparam int WaitCycles = 2;
    localparam int ErrWaitMax = 16;

    logic       clk, rst, cr_start;
    logic [7:0] link_bw_cr;
    logic [1:0] link_lc_cr;
    logic       aux_req_vld;
    logic [1:0] aux_op;
    logic       aux_ack, aux_rsp_vld, aux_rsp_err;
    logic [3:0] lane_cr_done;
    logic [7:0] adj_req_vtg, adj_req_pre;
    logic       cr_chk_start;
    logic [7:0] adj_vtg, adj_pre;
    logic       cr_completed, fsm_cr_failed;
    logic [7:0] new_bw_cr;
    logic [1:0] new_lc_cr;
    logic       drive_setting_flag, bw_flag, lc_flag, err_cr_failed;
    logic [7:0] cur_bw;
    logic [1:0] cur_lc;
    logic [7:0] vtg_set, pre_set;
    logic       busy, cr_done, cr_fail;

    int testsRun = 0;
    int failCount = 0;
    int cycleCount = 0;
    int complCount = 0;
    int failPulseCount = 0;
    int chkCount = 0;
    int lastGap = 0;
    int outcomeCycle = 0;
    int expOps[$];
    byte expOutcome[$];

    cr_train_ctrl #(.WAIT_CYCLES(WaitCycles), .ERR_WAIT_MAX(ErrWaitMax)) dut (
        .clk(clk), .rst(rst), .cr_start(cr_start), .link_bw_cr(link_bw_cr), .link_lc_cr(link_lc_cr),
        .aux_req_vld(aux_req_vld), .aux_op(aux_op), .aux_ack(aux_ack), .aux_rsp_vld(aux_rsp_vld),
        .aux_rsp_err(aux_rsp_err), .lane_cr_done(lane_cr_done), .adj_req_vtg(adj_req_vtg),
        .adj_req_pre(adj_req_pre), .cr_chk_start(cr_chk_start), .adj_vtg(adj_vtg), .adj_pre(adj_pre),
        .cr_completed(cr_completed), .fsm_cr_failed(fsm_cr_failed), .new_bw_cr(new_bw_cr),
        .new_lc_cr(new_lc_cr), .drive_setting_flag(drive_setting_flag), .bw_flag(bw_flag),
        .lc_flag(lc_flag), .err_cr_failed(err_cr_failed), .cur_bw(cur_bw), .cur_lc(cur_lc),
        .vtg_set(vtg_set), .pre_set(pre_set), .busy(busy), .cr_done(cr_done), .cr_fail(cr_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCount <= cycleCount + 1;

    always @(negedge clk) begin
        if (cr_completed) complCount <= complCount + 1;
        if (fsm_cr_failed) failPulseCount <= failPulseCount + 1;
        if (cr_chk_start) chkCount <= chkCount + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] bw, input logic [1:0] lc);
        cr_start   = 1'b1;
        link_bw_cr = bw;
        link_lc_cr = lc;
        @(negedge clk);
        cr_start = 1'b0;
        checkOutput("start busy", busy, 1'b1);
        checkOutput("start req", aux_req_vld, 1'b1);
        checkOutput("start clears done", cr_done, 1'b0);
        checkOutput("start clears fail", cr_fail, 1'b0);
    endtask

    // Serve one AUX request; a status read also returns a response.
    task automatic auxTxn(input int ackDelay, input bit rspWithAck, input logic [3:0] crDone,
                          input logic [7:0] vtg, input logic [7:0] pre, input bit rspErr);
        int  lowCnt;
        int  expOp;
        bit  seen;
        lowCnt = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (aux_req_vld) begin
                seen = 1'b1;
                break;
            end
            lowCnt++;
            @(negedge clk);
        end
        checkOutput("req raised", seen, 1'b1);
        if (!seen) return;
        lastGap = lowCnt;
        if (expOps.size() == 0) begin
            checkOutput("unexpected aux op", aux_op, 2'b11);
            expOp = 3;
        end else begin
            expOp = expOps.pop_front();
            checkOutput("aux op order", aux_op, expOp[1:0]);
        end
        for (int i = 0; i < ackDelay; i++) begin
            @(negedge clk);
            checkOutput("req held", aux_req_vld, 1'b1);
        end
        aux_ack = 1'b1;
        lane_cr_done = crDone;
        adj_req_vtg  = vtg;
        adj_req_pre  = pre;
        aux_rsp_err  = rspErr;
        if (expOp == 2 && rspWithAck) aux_rsp_vld = 1'b1;
        @(negedge clk);
        aux_ack     = 1'b0;
        aux_rsp_vld = 1'b0;
        checkOutput("req drop", aux_req_vld, 1'b0);
        if (expOp == 2 && !rspWithAck) begin
            aux_rsp_vld = 1'b1;
            @(negedge clk);
            aux_rsp_vld = 1'b0;
        end
    endtask

    task automatic waitOutcome();
        byte code;
        byte exp;
        code = "-";
        for (int i = 0; i < 60; i++) begin
            if (cr_completed) code = "P";
            else if (fsm_cr_failed) code = "F";
            else if (cr_chk_start) code = "C";
            if (code != "-") break;
            @(negedge clk);
        end
        outcomeCycle = cycleCount;
        if (expOutcome.size() == 0) begin
            checkOutput("unexpected outcome", code, "-");
            return;
        end
        exp = expOutcome.pop_front();
        checkOutput("outcome", code, exp);
        if (code == "P" || code == "F") begin
            checkOutput("busy in final state", busy, 1'b1);
            @(negedge clk);
            checkOutput("final pulse width", cr_completed | fsm_cr_failed, 1'b0);
            checkOutput("busy falls", busy, 1'b0);
        end
    endtask

    task automatic giveVerdict(input logic drv, input logic bwf, input logic lcf, input logic errf,
                               input logic [7:0] nbw, input logic [1:0] nlc);
        drive_setting_flag = drv;
        bw_flag            = bwf;
        lc_flag            = lcf;
        err_cr_failed      = errf;
        new_bw_cr          = nbw;
        new_lc_cr          = nlc;
        @(negedge clk);
        drive_setting_flag = 1'b0;
        bw_flag            = 1'b0;
        lc_flag            = 1'b0;
        err_cr_failed      = 1'b0;
        checkOutput("chk pulse width", cr_chk_start, 1'b0);
    endtask

    initial begin
        int savedCycle, savedCompl, savedFail, savedChk;
        rst = 1'b1; cr_start = 1'b0; link_bw_cr = '0; link_lc_cr = '0;
        aux_ack = 1'b0; aux_rsp_vld = 1'b0; aux_rsp_err = 1'b0; lane_cr_done = '0;
        adj_req_vtg = '0; adj_req_pre = '0; new_bw_cr = '0; new_lc_cr = '0;
        drive_setting_flag = 1'b0; bw_flag = 1'b0; lc_flag = 1'b0; err_cr_failed = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset req", aux_req_vld, 1'b0);
        checkOutput("reset bw", cur_bw, 8'h00);
        checkOutput("reset done/fail", {cr_done, cr_fail, cr_completed, fsm_cr_failed}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);

        // First-pass success at HBR2 x4
        expOps.push_back(0); expOps.push_back(1); expOps.push_back(2); expOutcome.push_back("P");
        applyStimulus(8'h14, 2'b11);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(2, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        checkOutput("gap before drive req", lastGap >= 1, 1'b1);
        auxTxn(0, 1'b0, 4'hF, 8'h00, 8'h00, 1'b0);
        checkOutput("wait interval length", lastGap, WaitCycles);
        waitOutcome();
        checkOutput("pass sticky done", cr_done, 1'b1);
        checkOutput("pass no fail", cr_fail, 1'b0);
        checkOutput("pass bw", cur_bw, 8'h14);
        checkOutput("pass lc", cur_lc, 2'b11);
        checkOutput("pass no chk", chkCount, 0);

        // Drive adjust with ack and response in the same cycle
        expOps.push_back(0); expOps.push_back(1); expOps.push_back(2); expOutcome.push_back("C");
        applyStimulus(8'h0A, 2'b01);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(1, 1'b1, 4'b0001, 8'h05, 8'h0A, 1'b0);
        waitOutcome();
        checkOutput("adj vtg latched", adj_vtg, 8'h05);
        checkOutput("adj pre latched", adj_pre, 8'h0A);
        expOps.push_back(1); expOps.push_back(2); expOutcome.push_back("P");
        giveVerdict(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
        checkOutput("drive vtg applied", vtg_set, 8'h05);
        checkOutput("drive pre applied", pre_set, 8'h0A);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b0, 4'b0011, 8'h0F, 8'h00, 1'b0);
        waitOutcome();
        checkOutput("drive adjust chk count", chkCount, 1);
        checkOutput("drive adjust done", cr_done, 1'b1);

        // Rate drop, then lane drop with rate change
        expOps.push_back(0); expOps.push_back(1); expOps.push_back(2); expOutcome.push_back("C");
        applyStimulus(8'h14, 2'b11);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b0, 4'b0111, 8'h11, 8'h22, 1'b0);
        waitOutcome();
        expOps.push_back(0); expOps.push_back(1); expOps.push_back(2); expOutcome.push_back("C");
        giveVerdict(1'b0, 1'b1, 1'b0, 1'b0, 8'h0A, 2'b01);
        checkOutput("bw flag rate", cur_bw, 8'h0A);
        checkOutput("bw flag keeps lc", cur_lc, 2'b11);
        checkOutput("bw flag vtg cleared", vtg_set, 8'h00);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b0, 4'b0011, 8'h00, 8'h00, 1'b0);
        waitOutcome();
        expOps.push_back(0); expOps.push_back(1); expOps.push_back(2); expOutcome.push_back("P");
        giveVerdict(1'b1, 1'b1, 1'b1, 1'b0, 8'h1E, 2'b01);
        checkOutput("lc flag lc", cur_lc, 2'b01);
        checkOutput("lc flag rate", cur_bw, 8'h1E);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b0, 4'b0011, 8'h00, 8'h00, 1'b0);
        waitOutcome();

        // Give-up verdict wins over drive flag; start while busy is ignored
        expOps.push_back(0); expOps.push_back(1); expOps.push_back(2); expOutcome.push_back("C");
        applyStimulus(8'h06, 2'b00);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        cr_start = 1'b1; link_bw_cr = 8'h1E;
        @(negedge clk);
        cr_start = 1'b0;
        checkOutput("start while busy ignored", cur_bw, 8'h06);
        auxTxn(0, 1'b0, 4'b0000, 8'h33, 8'h33, 1'b0);
        waitOutcome();
        expOutcome.push_back("F");
        giveVerdict(1'b1, 1'b0, 1'b0, 1'b1, 8'h14, 2'b11);
        waitOutcome();
        checkOutput("err sticky fail", cr_fail, 1'b1);
        checkOutput("err no done", cr_done, 1'b0);
        checkOutput("err priority vtg", vtg_set, 8'h00);

        // Read error with all lanes done, then verdict timeout
        expOps.push_back(0); expOps.push_back(1); expOps.push_back(2); expOutcome.push_back("C");
        applyStimulus(8'h14, 2'b11);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b1, 4'hF, 8'hAA, 8'h55, 1'b1);
        waitOutcome();
        checkOutput("rsp err keeps adj vtg", adj_vtg, 8'h00);
        checkOutput("rsp err keeps adj pre", adj_pre, 8'h00);
        savedCycle = outcomeCycle;
        expOutcome.push_back("F");
        @(negedge clk);
        waitOutcome();
        checkOutput("timeout length", outcomeCycle - savedCycle, ErrWaitMax);
        checkOutput("timeout sticky fail", cr_fail, 1'b1);

        // Reset during the training interval
        expOps.push_back(0); expOps.push_back(1);
        applyStimulus(8'h0A, 2'b01);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        auxTxn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        savedCompl = complCount; savedFail = failPulseCount; savedChk = chkCount;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort req", aux_req_vld, 1'b0);
        checkOutput("abort bw", cur_bw, 8'h00);
        checkOutput("abort lc", cur_lc, 2'b00);
        repeat (20) @(negedge clk);
        checkOutput("abort stays idle", {busy, aux_req_vld}, 2'b00);
        checkOutput("abort no pulses",
                    (complCount - savedCompl) + (failPulseCount - savedFail) + (chkCount - savedChk), 0);
        checkOutput("op queue drained", expOps.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/cr_train_ctrl.md
# cr_train_ctrl

Clock-recovery (CR) link-training sequencer for the DP source link policy path. On a start pulse from the LPM it:

- programs link rate, lane count and training pattern 1 over AUX;
- applies drive settings and waits the training interval;
- reads lane status and decides pass or fail.

On failure it hands the decision to the CR error-check block (`cr_chk_start` … `drive_setting_flag`/`bw_flag`/`lc_flag`/`err_cr_failed`) and re-enters the loop with the adjusted parameters.

## Interface
Parameters:
- `WAIT_CYCLES`, 400: training-interval length in `clk` cycles (≥2).
- `ERR_WAIT_MAX`, 16: cycles allowed for the error-check block to answer.

Ports (`clk`: one clock; `rst`: synchronous, active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `cr_start` in 1: one-cycle start pulse from LPM; ignored while `busy`.
- `link_bw_cr` in 8: initial link rate (0x06/0x0A/0x14/0x1E), captured on `cr_start`.
- `link_lc_cr` in 2: initial lane count (00=1, 01=2, 11=4), captured on `cr_start`.
- `aux_req_vld` out 1: AUX request valid.
- `aux_op` out 2: 00 = write link config + TPS1, 01 = write drive settings, 10 = read lane status.
- `aux_ack` in 1: one-cycle request accept.
- `aux_rsp_vld` in 1: one-cycle read response valid.
- `aux_rsp_err` in 1: read failed; qualifies `aux_rsp_vld`.
- `lane_cr_done` in 4: per-lane CR_DONE, valid with `aux_rsp_vld`.
- `adj_req_vtg` in 8: sink-requested voltage swing (2 bits per lane), valid with `aux_rsp_vld`.
- `adj_req_pre` in 8: sink-requested pre-emphasis (2 bits per lane), valid with `aux_rsp_vld`.
- `cr_chk_start` out 1: one-cycle pulse to the error-check block.
- `adj_vtg` out 8: last read voltage-swing request, held stable.
- `adj_pre` out 8: last read pre-emphasis request, held stable.
- `cr_completed` out 1: one-cycle pulse on CR pass.
- `fsm_cr_failed` out 1: one-cycle pulse on CR fail.
- `new_bw_cr` in 8: rate proposed by the error-check block.
- `new_lc_cr` in 2: lane count proposed by the error-check block.
- `drive_setting_flag` in 1: error-check verdict, adjust drive.
- `bw_flag` in 1: error-check verdict, new rate.
- `lc_flag` in 1: error-check verdict, new lane count.
- `err_cr_failed` in 1: error-check verdict, give up.
- `cur_bw` out 8: active link rate.
- `cur_lc` out 2: active lane count.
- `vtg_set` out 8: applied voltage swing.
- `pre_set` out 8: applied pre-emphasis.
- `busy` out 1: high from `cr_start` acceptance until DONE/FAIL exit.
- `cr_done` out 1: sticky pass level, cleared on next accepted `cr_start`.
- `cr_fail` out 1: sticky fail level, cleared on next accepted `cr_start`.

## Operation
- States: IDLE, WR_CFG, WR_DRV, WAIT_INT, RD_STS, EVAL, ERR_CHK, DONE, FAIL.
- IDLE → WR_CFG on `cr_start`.
  - Latches `cur_bw`/`cur_lc`.
  - Clears `vtg_set`/`pre_set`/`adj_*` to 0.
  - Clears `cr_done`/`cr_fail`.
- WR_CFG (`aux_op`=00), WR_DRV (01) and RD_STS (10) each assert `aux_req_vld` until `aux_ack`.
  - WR_CFG → WR_DRV.
  - WR_DRV → WAIT_INT.
  - RD_STS additionally waits for `aux_rsp_vld` after the ack, then → EVAL.
- WAIT_INT: counter loads `WAIT_CYCLES-1` on entry and counts down to 0, then → RD_STS.
- RD_STS latches the response into `adj_vtg`/`adj_pre` and a pass bit.
  - Lane mask: `cur_lc` 00 → 0001, 01 → 0011, 11 → 1111, 10 → 0001.
  - pass = (`lane_cr_done` & mask) == mask, and `aux_rsp_err` = 0.
  - When `aux_rsp_err` = 1, pass = 0 and `adj_*` keep their previous values.
- EVAL: pass → DONE; otherwise → ERR_CHK.
- ERR_CHK: pulses `cr_chk_start` on the entry cycle, then waits for a verdict flag.
  - Priority when several flags are high in the same cycle: `err_cr_failed` > `lc_flag` > `bw_flag` > `drive_setting_flag`.
  - `err_cr_failed` → FAIL.
  - `lc_flag` → `cur_lc` ← `new_lc_cr`, `cur_bw` ← `new_bw_cr`, drive values cleared, → WR_CFG.
  - `bw_flag` alone → `cur_bw` ← `new_bw_cr`, drive values cleared, → WR_CFG.
  - `drive_setting_flag` → `vtg_set` ← `adj_vtg`, `pre_set` ← `adj_pre`, → WR_DRV.
  - No flag within `ERR_WAIT_MAX` cycles → FAIL.
- DONE: pulses `cr_completed`, sets `cr_done`, → IDLE.
- FAIL: pulses `fsm_cr_failed`, sets `cr_fail`, → IDLE.
- `aux_rsp_vld` outside RD_STS and flags outside ERR_CHK are ignored.

## Timing
- Reset value of every output and register is 0; state = IDLE.
- `rst` asserted mid-training aborts on the next edge; no pulse is emitted.
- All outputs are registered.
- `cr_start` at edge N gives `busy` = 1 and `aux_req_vld` = 1 at edge N+1.
- `aux_req_vld` drops on the edge after `aux_ack` is sampled high.
  - An ack in the first valid cycle is legal.
  - The next request is not raised earlier than one cycle later.
- `aux_ack` and `aux_rsp_vld` in the same cycle: the response is accepted.
- WAIT_INT lasts exactly `WAIT_CYCLES` cycles.
- EVAL lasts one cycle.
- `cr_chk_start` is high for exactly one cycle; `adj_vtg`/`adj_pre` are stable from that cycle until the verdict.
- `cr_completed` and `fsm_cr_failed` are coincident with the DONE/FAIL state cycle.
- `busy` falls on the following edge.

## Structure
- Shared package `dp_lt_pkg` holds:
  - the state enum;
  - `aux_op` codes;
  - link-rate constants RBR = 0x06, HBR = 0x0A, HBR2 = 0x14, HBR3 = 0x1E;
  - the lane-count codes.
- One sub-module, `lt_wait_timer`: loadable down-counter with a done strobe. It is reused for WAIT_INT and the ERR_CHK timeout.

## Test plan
- **First-pass success:** `cr_start` with bw = 0x14, lc = 11; `lane_cr_done` = 1111 → op order 00, 01, 10; `cr_completed` one pulse; `cr_done` = 1; `cr_chk_start` never asserted.
- **Drive adjust:** lc = 01, status 0001 with `adj_req_vtg` = 0x05 → one `cr_chk_start`. `drive_setting_flag` → `vtg_set` = 0x05 and the next op is 01, not 00. Second status 0011 → DONE.
- **Rate drop then lane drop:**
  - `bw_flag` with `new_bw_cr` = 0x0A → `cur_bw` = 0x0A, `vtg_set` = 0, next op 00.
  - Later `lc_flag` + `bw_flag` with lc 01, bw 0x1E → `cur_lc` = 01, `cur_bw` = 0x1E.
- **Failure paths:**
  - `err_cr_failed` → `fsm_cr_failed` pulse, `cr_fail` = 1.
  - No flag for 16 cycles → FAIL.
  - `aux_rsp_err` with `lane_cr_done` = 1111 → treated as fail.
- **Boundaries:**
  - `cr_start` while `busy` is ignored.
  - `aux_ack` in the first valid cycle works.
  - `WAIT_CYCLES` = 2 gives exactly 2 cycles.
  - `rst` during WAIT_INT → all outputs 0 next cycle, no pulses.
